// File: rtl/display_pixel_source.sv
// Double-buffered frame store feeding a two-stage PWM compare pipeline.
// The host writes the back bank; swaps happen only on the driver's safe_flip strobe.
module display_pixel_source #(
  parameter int unsigned rows     = 8,
  parameter int unsigned columns  = 32,
  parameter int unsigned bitdepth = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [$clog2(rows)-1:0]                      row,
  input  logic [$clog2(columns)-1:0]                   column,
  input  logic [bitdepth-1:0]                          cycle,
  input  logic                                         safe_flip,
  input  logic                                         wr_en,
  input  logic [$clog2(rows)+$clog2(columns):0]        wr_addr,
  input  logic [3*bitdepth-1:0]                        wr_data,
  output logic                                         wr_ready,
  input  logic                                         flip_req,
  output logic                                         flip_pending,
  output logic                                         flip_done,
  output logic [5:0]                                   rgb
);

  localparam int unsigned RW    = $clog2(rows);
  localparam int unsigned CW    = $clog2(columns);
  localparam int unsigned AW    = 1 + RW + CW;
  localparam int unsigned DW    = 3 * bitdepth;
  localparam int unsigned B     = bitdepth;
  localparam int unsigned DEPTH = 2 * rows * columns;

  typedef enum logic {IDLE, PENDING} flip_state_e;

  flip_state_e       state_q, state_d;
  logic              front_sel_q, front_sel_d;
  logic              flip_done_q, flip_done_d;
  logic              flip_take;
  logic [DW-1:0]     up_q, up_d, lo_q, lo_d;
  logic [B-1:0]      cyc_q;
  logic [5:0]        rgb_q, rgb_d;
  logic [AW-1:0]     up_addr, lo_addr;

  logic [DW-1:0]     bank0_q [DEPTH];
  logic [DW-1:0]     bank1_q [DEPTH];

  // Flip handshake FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      flip_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      flip_done_q <= flip_done_d;
    end
  end

  // Next state: a request coinciding with safe_flip is taken at once and never parks in PENDING
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flip_req && !safe_flip) state_d = PENDING;
      PENDING: if (safe_flip) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    flip_pending = (state_q == PENDING);
    wr_ready     = (state_q != PENDING);
    flip_take    = safe_flip && ((state_q == PENDING) || flip_req);
    front_sel_d  = front_sel_q ^ flip_take;
    flip_done_d  = flip_take;
  end

  // Back-bank write port; bank contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (rst && wr_en && wr_ready) begin
      if (front_sel_q) bank0_q[wr_addr] <= wr_data;
      else             bank1_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    up_addr = {1'b0, row, column};
    lo_addr = {1'b1, row, column};
    up_d    = front_sel_q ? bank1_q[up_addr] : bank0_q[up_addr];
    lo_d    = front_sel_q ? bank1_q[lo_addr] : bank0_q[lo_addr];
    rgb_d   = {up_q[3*B-1:2*B] > cyc_q, up_q[2*B-1:B] > cyc_q, up_q[B-1:0] > cyc_q,
               lo_q[3*B-1:2*B] > cyc_q, lo_q[2*B-1:B] > cyc_q, lo_q[B-1:0] > cyc_q};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      up_q  <= '0;
      lo_q  <= '0;
      cyc_q <= '0;
      rgb_q <= '0;
    end else begin
      up_q  <= up_d;
      lo_q  <= lo_d;
      cyc_q <= cycle;
      rgb_q <= rgb_d;
    end
  end

  assign flip_done = flip_done_q;
  assign rgb       = rgb_q;

endmodule

// File: tb/tb_display_pixel_source.sv
// Directed bench for display_pixel_source: PWM compare, flip handshake, write blocking, reset.
module tb_display_pixel_source;

  logic        clk;
  logic        rst;
  logic [2:0]  row;
  logic [4:0]  column;
  logic [7:0]  cycle;
  logic        safe_flip;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_ready;
  logic        flip_req;
  logic        flip_pending;
  logic        flip_done;
  logic [5:0]  rgb;

  int errors = 0;
  int checks = 0;

  display_pixel_source #(.rows(8), .columns(32), .bitdepth(8)) dut (
    .clk(clk), .rst(rst), .row(row), .column(column), .cycle(cycle),
    .safe_flip(safe_flip), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .flip_req(flip_req), .flip_pending(flip_pending),
    .flip_done(flip_done), .rgb(rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [8:0] addr, input logic [23:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b0; row = '0; column = '0; cycle = '0; safe_flip = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; flip_req = 1'b0;
    tick(); tick();
    check("rst_pending", 32'(flip_pending), 32'd0);
    check("rst_done", 32'(flip_done), 32'd0);
    check("rst_rgb", 32'(rgb), 32'd0);
    check("rst_ready", 32'(wr_ready), 32'd1);
    rst = 1'b1;
    tick();

    // Back is bank1: upper {0,3,5} r=0x80, lower {1,3,5}=0
    write({1'b0, 3'd3, 5'd5}, 24'h800000);
    write({1'b1, 3'd3, 5'd5}, 24'h000000);
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    check("hs_pending", 32'(flip_pending), 32'd1);
    check("hs_ready", 32'(wr_ready), 32'd0);
    check("hs_done_early", 32'(flip_done), 32'd0);
    tick();
    check("hs_pending_hold", 32'(flip_pending), 32'd1);
    safe_flip = 1'b1; tick(); safe_flip = 1'b0;
    check("hs_done", 32'(flip_done), 32'd1);
    check("hs_pending_clr", 32'(flip_pending), 32'd0);
    check("hs_ready_back", 32'(wr_ready), 32'd1);
    tick();
    check("hs_done_pulse", 32'(flip_done), 32'd0);

    // PWM sweep on bank1 {0,3,5}; rgb reflects the cycle driven one iteration earlier
    row = 3'd3; column = 5'd5;
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) cycle = i[7:0];
      tick();
      if (i >= 1) begin
        check("pwm_r0", 32'(rgb[5]), 32'((i - 1) < 128));
        check("pwm_lower_zero", 32'(rgb[2:0]), 32'd0);
      end
    end

    // Simultaneous flip_req+safe_flip; toggle-cycle read still uses the old bank
    write({1'b0, 3'd3, 5'd5}, 24'h0000FF);
    cycle = 8'h10;
    tick(); tick();
    check("sim_before", 32'(rgb[5:3]), 32'b100);
    flip_req = 1'b1; safe_flip = 1'b1; tick(); flip_req = 1'b0; safe_flip = 1'b0;
    check("sim_done", 32'(flip_done), 32'd1);
    check("sim_pending", 32'(flip_pending), 32'd0);
    tick();
    check("sim_old_bank", 32'(rgb[5:3]), 32'b100);
    check("sim_done_pulse", 32'(flip_done), 32'd0);
    tick();
    check("sim_new_bank", 32'(rgb[5:3]), 32'b001);

    // Second request while pending plus held safe_flip: exactly one toggle
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    check("dbl_pending", 32'(flip_pending), 32'd1);
    tick();
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    check("dbl_pending2", 32'(flip_pending), 32'd1);
    safe_flip = 1'b1; tick();
    check("dbl_done", 32'(flip_done), 32'd1);
    check("dbl_pending_clr", 32'(flip_pending), 32'd0);
    tick();
    check("dbl_done_once", 32'(flip_done), 32'd0);
    tick();
    check("dbl_done_once2", 32'(flip_done), 32'd0);
    safe_flip = 1'b0;
    tick(); tick();
    check("dbl_one_toggle", 32'(rgb[5:3]), 32'b100);

    // Write while pending must not reach bank0
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    check("blk_ready", 32'(wr_ready), 32'd0);
    write({1'b0, 3'd3, 5'd5}, 24'hFF0000);
    safe_flip = 1'b1; tick(); safe_flip = 1'b0;
    tick(); tick();
    check("blk_unchanged", 32'(rgb[5:3]), 32'b001);

    // Lower half corner with g=0xFF in bank1
    write({1'b1, 3'd7, 5'd31}, 24'h00FF00);
    write({1'b0, 3'd7, 5'd31}, 24'h000000);
    flip_req = 1'b1; safe_flip = 1'b1; tick(); flip_req = 1'b0; safe_flip = 1'b0;
    row = 3'd7; column = 5'd31;
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) cycle = i[7:0];
      tick();
      if (i >= 1) check("ext_g1", 32'(rgb), 32'({4'b0000, (i - 1) != 255, 1'b0}));
    end

    // Reset mid-operation with a pending flip, a write and a request in the reset cycle
    row = 3'd3; column = 5'd5; cycle = 8'h10;
    tick(); tick();
    check("mid_rgb_lit", 32'(rgb), 32'b100000);
    flip_req = 1'b1; tick(); flip_req = 1'b0;
    check("mid_pending", 32'(flip_pending), 32'd1);
    rst = 1'b0; flip_req = 1'b1;
    wr_en = 1'b1; wr_addr = {1'b0, 3'd3, 5'd5}; wr_data = 24'h00FF00;
    tick();
    rst = 1'b1; flip_req = 1'b0; wr_en = 1'b0;
    check("mid_rgb", 32'(rgb), 32'd0);
    check("mid_pending_clr", 32'(flip_pending), 32'd0);
    check("mid_done", 32'(flip_done), 32'd0);
    check("mid_ready", 32'(wr_ready), 32'd1);
    tick();
    check("mid_pipe_flushed", 32'(rgb), 32'd0);
    check("mid_req_ignored", 32'(flip_pending), 32'd0);
    safe_flip = 1'b1; tick(); safe_flip = 1'b0;
    check("mid_no_toggle_done", 32'(flip_done), 32'd0);
    tick(); tick();
    check("mid_front_bank0", 32'(rgb[5:3]), 32'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
